// File: rtl/keypad_scan_controller_pkg.sv
// Purpose: shared definitions for the keypad scan peripheral.
//   Register offsets of the CPU window, CTRL bit positions, the key-code
//   width, the scan sequencer state type and two small bit helpers used
//   by the press-event logic.
// Ports: none (package).
package keypad_scan_controller_pkg;

   localparam logic [1:0] KPD_STATUS = 2'd0;
   localparam logic [1:0] KPD_DATA   = 2'd1;
   localparam logic [1:0] KPD_CTRL   = 2'd2;

   localparam int CTRL_IE_BIT    = 0;
   localparam int CTRL_FLUSH_BIT = 1;
   localparam int CTRL_CLEAR_BIT = 2;

   localparam int KEY_CODE_W = 4;

   typedef enum logic {
      SCAN_IDLE,
      SCAN_RUN
   } scan_state_t;

   // Index of the lowest set bit; the caller only uses it when some bit is set.
   function automatic logic [KEY_CODE_W-1:0] lowest_set_index(input logic [15:0] bits);
      logic [KEY_CODE_W-1:0] idx;
      idx = '0;
      for (int i = 15; i >= 0; i--) begin
         if (bits[i]) begin
            idx = KEY_CODE_W'(i);
         end
      end
      return idx;
   endfunction

   // True when two or more bits are set (clearing the lowest still leaves one).
   function automatic logic more_than_one(input logic [15:0] bits);
      return (bits & (bits - 16'd1)) != 16'd0;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Purpose: small synchronous FIFO with push/pop/flush, used for keypad
//   events and reusable by later serial peripherals.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   push, push_data    write request and data (ignored while full unless popping)
//   pop                read request (ignored while empty)
//   flush              empties the FIFO; wins over a same-cycle push and pop
//   head               entry at the read pointer (valid when not empty)
//   full, empty, count occupancy status
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   // A pop frees a slot in the same cycle, so a full FIFO still accepts
   // a push that coincides with a pop.
   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   // Storage array is kept out of the reset path; only the pointers
   // decide what is valid.
   always_ff @(posedge clk) begin
      if (!rst && !flush && do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/keypad_scan_controller.sv
// Purpose: scans a 4x4 active-low matrix keypad one row at a time,
//   debounces whole-matrix frames, queues key-press codes in a FIFO and
//   exposes STATUS/DATA/CTRL registers to the CPU.
// Ports:
//   clk, rst      peripheral clock, synchronous active-high reset
//   rows          row drive, active-low, one row low at a time
//   cols          column sense, active-low, asynchronous
//   sel, address, writeEnable, din   bus strobe, register select, direction, write data
//   dout          registered read data
//   irq           FIFO non-empty and interrupts enabled
module keypad_scan_controller
   import keypad_scan_controller_pkg::*;
#(
   parameter int SCAN_DIV       = 64,
   parameter int DEBOUNCE_SCANS = 3,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic        clk,
   input  logic        rst,
   output logic [3:0]  rows,
   input  logic [3:0]  cols,
   input  logic        sel,
   input  logic [1:0]  address,
   input  logic        writeEnable,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        irq
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam int DB_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_SCANS);

   scan_state_t       scan_state;
   logic [3:0]        cols_meta;
   logic [3:0]        cols_sync;
   logic [DIV_W-1:0]  div_cnt;
   logic [1:0]        row_idx;
   logic [1:0]        row_next;
   logic [15:0]       snapshot;
   logic [15:0]       prev_frame;
   logic [15:0]       stable_map;
   logic [DB_W-1:0]   match_cnt;
   logic [DB_W-1:0]   match_next;
   logic [15:0]       frame;
   logic [15:0]       new_presses;
   logic              row_done;
   logic              frame_done;
   logic              accept;
   logic              key_push;
   logic [KEY_CODE_W-1:0] key_code;

   logic              ie;
   logic              overflow;
   logic              multi;

   logic              rd_strobe;
   logic              wr_strobe;
   logic              ctrl_write;
   logic              fifo_pop;
   logic              fifo_flush;
   logic              push_dropped;
   logic [KEY_CODE_W-1:0] fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic [3:0]        count4;
   logic              unused_din;

   assign unused_din = ^din[31:3];

   // Two-flop synchronizer on the asynchronous column inputs; idle high.
   always_ff @(posedge clk) begin
      if (rst) begin
         cols_meta <= 4'hF;
         cols_sync <= 4'hF;
      end else begin
         cols_meta <= cols;
         cols_sync <= cols_meta;
      end
   end

   // Frame-end decisions. The last row is not yet in the snapshot register,
   // so the full frame is assembled from the live synchronized columns.
   always_comb begin
      row_done    = (scan_state == SCAN_RUN) && (div_cnt == DIV_LAST);
      frame_done  = row_done && (row_idx == 2'd3);
      row_next    = row_idx + 2'd1;
      frame       = {~cols_sync, snapshot[11:0]};
      if (frame == prev_frame) begin
         match_next = (match_cnt == DB_MAX) ? DB_MAX : match_cnt + 1'b1;
      end else begin
         match_next = DB_W'(1);
      end
      accept      = frame_done && (match_next == DB_MAX);
      new_presses = frame & ~stable_map;
      key_push    = accept && (new_presses != 16'd0);
      key_code    = lowest_set_index(new_presses);
   end

   // Row scan sequencer. IDLE lasts exactly one cycle after reset so row 0
   // goes low on the first clock with reset released; each row is then held
   // for SCAN_DIV cycles and its columns captured on the last one.
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_state <= SCAN_IDLE;
         rows       <= 4'hF;
         div_cnt    <= '0;
         row_idx    <= 2'd0;
         snapshot   <= '0;
         prev_frame <= '0;
         match_cnt  <= '0;
         stable_map <= '0;
      end else begin
         case (scan_state)
            SCAN_IDLE: begin
               scan_state <= SCAN_RUN;
               rows       <= 4'b1110;
               div_cnt    <= '0;
               row_idx    <= 2'd0;
            end
            SCAN_RUN: begin
               if (row_done) begin
                  div_cnt <= '0;
                  row_idx <= row_next;
                  rows    <= ~(4'b0001 << row_next);
                  snapshot[{row_idx, 2'b00} +: 4] <= ~cols_sync;
                  if (frame_done) begin
                     prev_frame <= frame;
                     match_cnt  <= match_next;
                     if (accept) begin
                        stable_map <= frame;
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            default: scan_state <= SCAN_IDLE;
         endcase
      end
   end

   // Bus decode. A DATA read pops only when there is something to return;
   // a flush beats any push from the scanner in the same cycle.
   always_comb begin
      rd_strobe    = sel & ~writeEnable;
      wr_strobe    = sel & writeEnable;
      ctrl_write   = wr_strobe && (address == KPD_CTRL);
      fifo_pop     = rd_strobe && (address == KPD_DATA) && !fifo_empty;
      fifo_flush   = ctrl_write && din[CTRL_FLUSH_BIT];
      push_dropped = key_push && fifo_full && !fifo_pop && !fifo_flush;
      count4       = 4'(fifo_count);
   end

   sync_fifo #(
      .WIDTH (KEY_CODE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (key_push),
      .push_data (key_code),
      .pop       (fifo_pop),
      .flush     (fifo_flush),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Control/status flags and registered read data. Sticky flag sets are
   // placed after the CTRL clear so an event in the clearing cycle is kept.
   always_ff @(posedge clk) begin
      if (rst) begin
         ie       <= 1'b0;
         overflow <= 1'b0;
         multi    <= 1'b0;
         dout     <= '0;
      end else begin
         if (ctrl_write) begin
            ie <= din[CTRL_IE_BIT];
            if (din[CTRL_CLEAR_BIT]) begin
               overflow <= 1'b0;
               multi    <= 1'b0;
            end
         end
         if (push_dropped) begin
            overflow <= 1'b1;
         end
         if (key_push && more_than_one(new_presses)) begin
            multi <= 1'b1;
         end
         if (rd_strobe) begin
            case (address)
               KPD_STATUS: dout <= {24'b0, count4, ie, multi, overflow, ~fifo_empty};
               KPD_DATA:   dout <= fifo_empty ? 32'd0 : {27'b0, 1'b1, fifo_head};
               KPD_CTRL:   dout <= {31'b0, ie};
               default:    dout <= 32'd0;
            endcase
         end
      end
   end

   assign irq = ~fifo_empty & ie;

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Purpose: directed self-checking bench for keypad_scan_controller with a
//   behavioural keypad matrix that pulls columns low for pressed keys on
//   the currently driven row.
// Ports: none (top-level bench).
module tb_keypad_scan_controller;
   import keypad_scan_controller_pkg::*;

   logic        clk;
   logic        rst;
   logic [3:0]  rows;
   logic [3:0]  cols;
   logic        sel;
   logic [1:0]  address;
   logic        writeEnable;
   logic [31:0] din;
   logic [31:0] dout;
   logic        irq;
   logic [15:0] keys;
   logic [31:0] rd_data;
   int          checks;
   int          errors;

   keypad_scan_controller #(
      .SCAN_DIV       (4),
      .DEBOUNCE_SCANS (2),
      .FIFO_DEPTH     (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rows        (rows),
      .cols        (cols),
      .sel         (sel),
      .address     (address),
      .writeEnable (writeEnable),
      .din         (din),
      .dout        (dout),
      .irq         (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad matrix: a pressed key at (r,c) pulls column c low while row r is driven low.
   always_comb begin
      cols = 4'hF;
      for (int r = 0; r < 4; r++) begin
         if (!rows[r]) begin
            for (int c = 0; c < 4; c++) begin
               if (keys[r*4 + c]) begin
                  cols[c] = 1'b0;
               end
            end
         end
      end
   end

   // Comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Holds a key pattern for a number of clock cycles.
   task automatic applyStimulus(input logic [15:0] pattern, input int cycles);
      keys = pattern;
      repeat (cycles) @(negedge clk);
   endtask

   // One-cycle read strobe; dout is sampled on the following falling edge.
   task automatic busRead(input logic [1:0] a, output logic [31:0] data);
      sel = 1'b1;
      writeEnable = 1'b0;
      address = a;
      @(negedge clk);
      sel = 1'b0;
      data = dout;
   endtask

   // One-cycle write strobe.
   task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
      sel = 1'b1;
      writeEnable = 1'b1;
      address = a;
      din = d;
      @(negedge clk);
      sel = 1'b0;
      writeEnable = 1'b0;
      din = 32'd0;
   endtask

   // Waits (bounded) for the edge on which row 0 becomes driven.
   task automatic waitFrameStart();
      logic [3:0] last_rows;
      logic       found;
      found = 1'b0;
      last_rows = rows;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (rows == 4'b1110 && last_rows != 4'b1110) found = 1'b1;
         last_rows = rows;
      end
      checkOutput("frame_start_seen", {31'b0, found}, 32'd1);
   endtask

   initial begin
      logic [15:0] press_keys [5];
      logic [31:0] press_codes [5];
      logic        irq_seen;

      checks = 0;
      errors = 0;
      rst = 1'b1;
      sel = 1'b0;
      writeEnable = 1'b0;
      address = 2'd0;
      din = 32'd0;
      keys = 16'd0;
      press_keys  = '{16'h0008, 16'h0040, 16'h0200, 16'h1000, 16'h4000};
      press_codes = '{32'h13, 32'h16, 32'h19, 32'h1C, 32'h1E};

      $display("[TB] reset state");
      repeat (3) @(negedge clk);
      checkOutput("reset_rows", {28'b0, rows}, 32'hF);
      checkOutput("reset_dout", dout, 32'h0);
      checkOutput("reset_irq", {31'b0, irq}, 32'h0);

      $display("[TB] row sequence after reset release");
      rst = 1'b0;
      @(negedge clk);
      checkOutput("row0", {28'b0, rows}, 32'hE);
      repeat (4) @(negedge clk);
      checkOutput("row1", {28'b0, rows}, 32'hD);
      repeat (4) @(negedge clk);
      checkOutput("row2", {28'b0, rows}, 32'hB);
      repeat (4) @(negedge clk);
      checkOutput("row3", {28'b0, rows}, 32'h7);
      repeat (4) @(negedge clk);
      checkOutput("row_wrap", {28'b0, rows}, 32'hE);
      busRead(KPD_STATUS, rd_data);
      checkOutput("status_idle", rd_data, 32'h0);

      $display("[TB] single held key row2/col1");
      applyStimulus(16'h0200, 64);
      applyStimulus(16'h0000, 64);
      busRead(KPD_STATUS, rd_data);
      checkOutput("status_one_event", rd_data, 32'h11);
      busRead(KPD_DATA, rd_data);
      checkOutput("data_key9", rd_data, 32'h19);
      busRead(KPD_STATUS, rd_data);
      checkOutput("status_after_pop", rd_data, 32'h0);
      busRead(KPD_CTRL, rd_data);
      checkOutput("ctrl_ie_off", rd_data, 32'h0);
      busRead(2'd3, rd_data);
      checkOutput("addr3_zero", rd_data, 32'h0);

      $display("[TB] key present for one frame only");
      waitFrameStart();
      applyStimulus(16'h0200, 16);
      applyStimulus(16'h0000, 64);
      busRead(KPD_STATUS, rd_data);
      checkOutput("status_short_press", rd_data, 32'h0);

      $display("[TB] keys 0 and 5 together");
      applyStimulus(16'h0021, 64);
      applyStimulus(16'h0000, 64);
      busRead(KPD_DATA, rd_data);
      checkOutput("data_multi_lowest", rd_data, 32'h10);
      busRead(KPD_STATUS, rd_data);
      checkOutput("status_multi", rd_data, 32'h4);
      busRead(KPD_DATA, rd_data);
      checkOutput("data_empty_after_multi", rd_data, 32'h0);
      busWrite(KPD_CTRL, 32'h4);
      busRead(KPD_STATUS, rd_data);
      checkOutput("status_multi_cleared", rd_data, 32'h0);

      $display("[TB] five presses into a depth-4 FIFO");
      for (int k = 0; k < 5; k++) begin
         applyStimulus(press_keys[k], 64);
         applyStimulus(16'h0000, 64);
      end
      busRead(KPD_STATUS, rd_data);
      checkOutput("status_full_overflow", rd_data, 32'h43);
      for (int k = 0; k < 4; k++) begin
         busRead(KPD_DATA, rd_data);
         checkOutput($sformatf("data_order_%0d", k), rd_data, press_codes[k]);
      end
      busRead(KPD_DATA, rd_data);
      checkOutput("data_fifth_empty", rd_data, 32'h0);
      busRead(KPD_STATUS, rd_data);
      checkOutput("status_overflow_sticky", rd_data, 32'h2);
      busWrite(KPD_CTRL, 32'h4);
      busRead(KPD_STATUS, rd_data);
      checkOutput("status_overflow_cleared", rd_data, 32'h0);

      $display("[TB] interrupt and flush");
      busWrite(KPD_CTRL, 32'h1);
      checkOutput("irq_low_when_empty", {31'b0, irq}, 32'h0);
      busRead(KPD_CTRL, rd_data);
      checkOutput("ctrl_ie_on", rd_data, 32'h1);
      keys = 16'h8000;
      irq_seen = 1'b0;
      for (int i = 0; i < 100 && !irq_seen; i++) begin
         @(negedge clk);
         irq_seen = irq;
      end
      checkOutput("irq_rise", {31'b0, irq_seen}, 32'h1);
      busRead(KPD_STATUS, rd_data);
      checkOutput("status_ie_nonempty", rd_data, 32'h19);
      checkOutput("irq_before_flush", {31'b0, irq}, 32'h1);
      busWrite(KPD_CTRL, 32'h3);
      checkOutput("irq_after_flush", {31'b0, irq}, 32'h0);
      busRead(KPD_STATUS, rd_data);
      checkOutput("status_flushed", rd_data, 32'h8);

      $display("[TB] reset mid-frame with key 15 still held");
      waitFrameStart();
      repeat (6) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("midreset_rows", {28'b0, rows}, 32'hF);
      checkOutput("midreset_dout", dout, 32'h0);
      checkOutput("midreset_irq", {31'b0, irq}, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midreset_row0", {28'b0, rows}, 32'hE);
      busRead(KPD_STATUS, rd_data);
      checkOutput("midreset_status", rd_data, 32'h0);
      applyStimulus(16'h8000, 64);
      busRead(KPD_STATUS, rd_data);
      checkOutput("status_rereport", rd_data, 32'h11);
      busRead(KPD_DATA, rd_data);
      checkOutput("data_key15", rd_data, 32'h1F);
      applyStimulus(16'h0000, 16);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/keypad_scan_controller.md
Name: keypad_scan_controller

Overview:
- Sequences the 4x4 matrix keypad on GPIO_1: drives one row at a time, samples the column inputs, debounces each key and queues press events in a small FIFO.
- The CPU reads the FIFO through a memory-mapped register window, in parallel with the HEX display registers in the peripheral space.
- Runs on the divided peripheral clock, so all timing is counted in clk cycles.

Parameters:
- SCAN_DIV, 64, clk cycles each row is held driven; must be >= 4.
- DEBOUNCE_SCANS, 3, consecutive identical full-matrix frames required before a key state change is accepted; must be >= 1.
- FIFO_DEPTH, 8, number of key events buffered; must be a power of two, >= 2.

Ports:
- clk  in  1  peripheral clock.
- rst  in  1  synchronous, active-high reset.
- rows  out  4  keypad row drive, active-low; one row low at a time.
- cols  in  4  keypad column sense, active-low (pulled up), asynchronous.
- sel  in  1  bus strobe for this block.
- address  in  2  register select: 0 STATUS, 1 DATA, 2 CTRL.
- writeEnable  in  1  1 = write, 0 = read (qualified by sel).
- din  in  32  write data.
- dout  out  32  registered read data.
- irq  out  1  high while the FIFO is non-empty and CTRL.ie = 1.

Behaviour:
- Reset state: rows = 4'hF, dout = 0, irq = 0, FIFO empty, overflow = 0, multi = 0, ie = 0, stable key map = 0, row index = 0, divider = 0.
- Column synchronizer: cols pass through a 2-flop synchronizer. The sampled value is the synchronized value.
- Scan, row phase:
  - In the first cycle after rst deasserts, row 0 is driven low.
  - Each row stays driven for SCAN_DIV cycles.
  - Synchronized cols are captured on the last cycle of the row period, as the active-high bits ~cols.
  - The row index then wraps 3 -> 0.
- Scan, frame phase:
  - One frame = 4 row periods, giving a 16-bit snapshot. Bit index is row*4 + col.
  - At frame end, snapshot == previous snapshot increments the match counter, saturating at DEBOUNCE_SCANS. Otherwise the counter is cleared to 1.
  - When the counter reaches DEBOUNCE_SCANS, the snapshot is loaded into the stable map.
- Press events:
  - A stable-map bit going 0->1 is a press.
  - Only the lowest-index new press is pushed, as a 4-bit code equal to its bit index.
  - Any further new presses in the same update are absorbed into the stable map, not pushed, and set sticky multi.
  - Releases (1->0) generate no event.
- FIFO rules:
  - A push while full drops the code and sets sticky overflow.
  - A push and a pop in the same cycle both occur; count is unchanged. If the FIFO was full, that push is accepted, not an overflow.
- Register reads (sel=1, writeEnable=0): dout updates on the next edge; otherwise dout holds.
  - STATUS = {24'b0, count[3:0], ie, multi, overflow, nonempty}.
  - DATA = {27'b0, valid, code[3:0]}. If the FIFO is non-empty: valid = 1, code = head entry, and the FIFO pops in the strobe cycle. If empty: returns 0, no pop.
  - CTRL reads back {31'b0, ie}.
  - Address 3 reads 0.
- Register writes (sel=1, writeEnable=1):
  - CTRL: din[0] sets ie.
  - CTRL: din[1]=1 flushes the FIFO.
  - CTRL: din[2]=1 clears overflow and multi.
  - A flush coinciding with a push wins: FIFO ends empty.
  - Writes to STATUS and DATA are ignored.
- rst asserted mid-frame: scan restarts at row 0 and the partial snapshot is discarded. A key held through reset is reported again after debounce.
- irq is combinational from registered state: nonempty & ie.

Decomposition:
- Shared peripheral package holds:
  - register offsets: KPD_STATUS = 0, KPD_DATA = 1, KPD_CTRL = 2;
  - CTRL bit positions;
  - the key-code width constant of 4.
- One natural sub-module, sync_fifo (parameterised width/depth, push/pop/flush, full/empty/count). It is reusable by later UART peripherals.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2, FIFO_DEPTH=4):
- Reset release -> rows cycles E,D,B,7 every 4 clocks; a STATUS read returns 0x0.
- Hold key row2/col1 (cols=4'b1101 while rows=4'b1011) for 3 frames -> exactly one event. STATUS = 0x00000011, DATA read = 0x19, then STATUS = 0x0.
- Key present for 1 frame only -> no event.
- Press keys 0 and 5 together -> DATA = 0x10, multi set (STATUS bit2); CTRL write 0x4 clears it.
- Press and release 5 distinct keys, no reads -> STATUS shows count 4 and overflow = 1. Four DATA reads return codes in press order; a fifth read returns 0x0.
- Set ie (CTRL = 0x1), press key 15 -> irq rises with nonempty. CTRL = 0x3 flushes the FIFO and irq drops the next cycle. Assert rst mid-frame -> rows = 4'hF and all state cleared.
